// File: rtl/if_id_field_reg.sv
// IF/ID pipeline register with MIPS instruction field split, link address and
// a saturating consecutive-stall counter.
module if_id_field_reg #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallD,
  input  logic             flushD,
  input  logic [31:0]      instrF,
  input  logic [PC_W-1:0]  pcF,
  input  logic             validF,
  output logic [31:0]      instrD,
  output logic [PC_W-1:0]  pcD,
  output logic [PC_W-1:0]  pc8D,
  output logic             validD,
  output logic             adelD,
  output logic [5:0]       op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [25:0]      imm26,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      instr_q, instr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             adel_q, adel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    cnt_d   = '0;
    if (reset) begin
      instr_d = NOP_INSTR;
      pc_d    = RESET_PC[PC_W-1:0];
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (flushD) begin
      // PC is kept on a bubble so exception bookkeeping still sees it.
      instr_d = NOP_INSTR;
      pc_d    = pcF;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end else if (stallD) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end else begin
      instr_d = instrF;
      pc_d    = pcF;
      valid_d = validF;
      adel_d  = validF & (pcF[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
    valid_q <= valid_d;
    adel_q  <= adel_d;
    cnt_q   <= cnt_d;
  end

  assign instrD    = instr_q;
  assign pcD       = pc_q;
  assign pc8D      = pc_q + PC_W'(8);
  assign validD    = valid_q;
  assign adelD     = adel_q;
  assign stall_cnt = cnt_q;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];
  assign imm26 = instr_q[25:0];

endmodule

// File: doc/if_id_field_reg.md
Name: if_id_field_reg

Overview:
- Parametrised IF/ID pipeline register and instruction field splitter for the five-stage MIPS core.
- Captures the fetched instruction, its PC, a valid bit and a PC-misalignment flag at each clock edge.
- Supports stall (hold), flush (bubble insert) and reset.
- Drives the decoded MIPS fields (op/rs/rt/rd/shamt/funct/imm16/imm26), the link address PC+8 and a saturating consecutive-stall counter to the D stage.

Parameters:
- PC_W, 32, width of the PC path (min 4, max 32).
- RESET_PC, 32'h0000_3000, value loaded into pcD on reset, truncated to PC_W bits.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush/reset.
- CNT_W, 8, width of the stall_cnt saturating counter.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- stallD  in  1  hold D-stage register contents.
- flushD  in  1  replace D-stage contents with a bubble.
- instrF  in  32  instruction from IM.
- pcF  in  PC_W  PC of instrF.
- validF  in  1  instrF is a real instruction.
- instrD  out  32  registered instruction.
- pcD  out  PC_W  registered PC.
- pc8D  out  PC_W  pcD + 8, for jal/jalr link.
- validD  out  1  registered valid.
- adelD  out  1  registered (pcF[1:0] != 0) & validF.
- op  out  6  instrD[31:26].
- rs  out  5  instrD[25:21].
- rt  out  5  instrD[20:16].
- rd  out  5  instrD[15:11].
- shamt  out  5  instrD[10:6].
- funct  out  6  instrD[5:0].
- imm16  out  16  instrD[15:0].
- imm26  out  26  instrD[25:0].
- stall_cnt  out  CNT_W  consecutive cycles stallD has held this register.

Behaviour:
- Single clock domain. All state updates on the rising clk edge, with priority reset > flushD > stallD > load.
- Reset (synchronous, active-high): instrD=NOP_INSTR, pcD=RESET_PC[PC_W-1:0], validD=0, adelD=0, stall_cnt=0.
  - Reset asserted mid-stall or mid-flush wins unconditionally on that edge.
- Flush (flushD=1, reset=0): instrD=NOP_INSTR, pcD=pcF (kept for exception-PC bookkeeping), validD=0, adelD=0, stall_cnt=0.
  - Flush overrides a simultaneous stallD=1.
- Stall (stallD=1, flushD=0, reset=0): instrD, pcD, validD and adelD hold their values.
  - stall_cnt = stall_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- Load (stallD=0, flushD=0, reset=0): instrD=instrF, pcD=pcF, validD=validF, adelD=validF & (pcF[1:0]!=0), stall_cnt=0.
- Latency: instrF/pcF appear on instrD/pcD exactly one cycle after the load edge. Zero-latency hold while stalled.
- Field outputs (op..imm26) are purely combinational slices of the registered instrD.
  - No added latency; they change only at clock edges.
  - After reset or flush they decode NOP_INSTR (all-zero for the default).
- pc8D = pcD + 8, computed modulo 2^PC_W (wraps, no carry out). Combinational from pcD.
- A misaligned PC is captured but does not alter instrD. Downstream exception logic consumes adelD.
- validF=0 on a load edge registers validD=0 but still captures instrF/pcF unchanged.
- X on stallD/flushD during reset is don't-care. Outside reset, inputs must be known.

Test Plan:
- Reset then idle:
  - reset=1 one edge -> instrD=0, pcD=0x00003000, pc8D=0x00003008, validD=0, stall_cnt=0, all fields 0.
- Normal load:
  - instrF=0x8D09_0004 (lw), pcF=0x3004, validF=1 -> next cycle op=0x23, rs=8, rt=9, imm16=0x0004, pcD=0x3004, validD=1.
  - instrF=0x0C00_0C10 (jal) -> imm26=0x0000C10.
- Stall hold and counter:
  - load 0x0128_5020 (add), then stallD=1 for 3 edges while instrF changes -> instrD stays 0x01285020, rd=10, funct=0x20, stall_cnt steps 1,2,3.
  - Release stall -> stall_cnt=0 and the new instrF is loaded.
  - With CNT_W=2, 5 stall edges -> stall_cnt saturates at 3.
- Flush beats stall:
  - stallD=1 and flushD=1 with pcF=0x3010 -> instrD=0, validD=0, pcD=0x3010, stall_cnt=0.
- Misaligned PC and wrap:
  - pcF=0x3006, validF=1 -> adelD=1, instrD=instrF.
  - PC_W=32, pcF=0xFFFF_FFFC -> pc8D=0x0000_0004.
- Reset mid-stall:
  - stall_cnt=5 with reset=1 and stallD=1 -> all outputs at their reset values on that edge.
